// File: rtl/inst_cache.sv
// Direct-mapped, one-word-per-line instruction cache that sits in front of instruction fetch.
// A lookup has 1-cycle latency. A miss issues a single-word memory read, installs the word and returns to lookup.
module inst_cache #(
    parameter int unsigned INDEX_BITS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic [31:0] pc_in,
    input  logic        flush,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_done,
    input  logic [31:0] mem_data
);

    localparam int unsigned LINES = 2 ** INDEX_BITS;
    localparam int unsigned TAG_W = 32 - INDEX_BITS - 2;

    typedef enum logic {
        IDLE,
        MISS
    } state_t;

    state_t            state_q;
    logic [LINES-1:0]  valid_q;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [31:0]       data_q [LINES];

    logic              instr_valid_q;
    logic [31:0]       instr_q;
    logic [31:0]       instr_pc_q;
    logic              mem_req_q;
    logic [31:0]       mem_addr_q;

    logic [31:0]           lk_addr;
    logic [INDEX_BITS-1:0] lk_idx;
    logic [TAG_W-1:0]      lk_tag;
    logic                  lk_hit;
    logic [INDEX_BITS-1:0] fill_idx;
    logic [TAG_W-1:0]      fill_tag;
    logic                  fill_we;
    logic                  unused_pc_bits;

    assign lk_addr        = {pc_in[31:2], 2'b00};
    assign lk_idx         = pc_in[INDEX_BITS+1:2];
    assign lk_tag         = pc_in[31:INDEX_BITS+2];
    assign lk_hit         = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign unused_pc_bits = ^pc_in[1:0];

    // The fill location comes from the held request address, never from the current pc_in.
    assign fill_idx = mem_addr_q[INDEX_BITS+1:2];
    assign fill_tag = mem_addr_q[31:INDEX_BITS+2];
    assign fill_we  = !rst && rdy && (state_q == MISS) && mem_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            valid_q       <= '0;
            instr_valid_q <= 1'b0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= '0;
        end else if (rdy) begin
            case (state_q)
                IDLE: begin
                    if (flush) begin
                        instr_valid_q <= 1'b0;
                    end else if (lk_hit) begin
                        instr_valid_q <= 1'b1;
                        instr_q       <= data_q[lk_idx];
                        instr_pc_q    <= lk_addr;
                    end else begin
                        instr_valid_q <= 1'b0;
                        mem_req_q     <= 1'b1;
                        mem_addr_q    <= lk_addr;
                        state_q       <= MISS;
                    end
                end
                MISS: begin
                    // A flush here only suppresses delivery; the fill always completes.
                    instr_valid_q <= 1'b0;
                    if (mem_done) begin
                        valid_q[fill_idx] <= 1'b1;
                        mem_req_q         <= 1'b0;
                        state_q           <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (fill_we) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= mem_data;
        end
    end

    assign instr_valid = instr_valid_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;

endmodule

// File: tb/tb_inst_cache.sv
// Bench for inst_cache: directed scenarios plus a randomized run checked against a line-map reference model.
module tb_inst_cache;

    localparam int LINES = 256;

    logic        clk = 1'b0;
    logic        rst, rdy, flush, mem_done;
    logic [31:0] pc_in, mem_data;
    logic        instr_valid, mem_req;
    logic [31:0] instr, instr_pc, mem_addr;

    int vectors = 0;
    int errors  = 0;

    // Reference model: per-line word address and data, one pending fill, expected outputs.
    logic [31:0] c_addr [int];
    logic [31:0] c_data [int];
    bit          m_miss = 0;
    logic        e_v, e_req;
    logic [31:0] e_instr, e_pc, e_addr;

    inst_cache #(.INDEX_BITS(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .rdy         (rdy),
        .pc_in       (pc_in),
        .flush       (flush),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_done    (mem_done),
        .mem_data    (mem_data)
    );

    always #5 clk = ~clk;

    task automatic model_update(input logic r, input logic rd, input logic [31:0] pc,
                                input logic fl, input logic dn, input logic [31:0] dt);
        logic [31:0] a;
        int          idx;
        if (r) begin
            c_addr.delete();
            c_data.delete();
            m_miss = 0;
            e_v = 0; e_instr = 0; e_pc = 0; e_req = 0; e_addr = 0;
        end else if (rd) begin
            if (!m_miss) begin
                if (fl) begin
                    e_v = 0;
                end else begin
                    a   = pc & 32'hFFFF_FFFC;
                    idx = int'((a / 4) % LINES);
                    if (c_addr.exists(idx) && c_addr[idx] == a) begin
                        e_v = 1; e_instr = c_data[idx]; e_pc = a;
                    end else begin
                        e_v = 0; e_req = 1; e_addr = a; m_miss = 1;
                    end
                end
            end else begin
                e_v = 0;
                if (dn) begin
                    idx = int'((e_addr / 4) % LINES);
                    c_addr[idx] = e_addr;
                    c_data[idx] = dt;
                    e_req  = 0;
                    m_miss = 0;
                end
            end
        end
    endtask

    task automatic step(input logic r, input logic rd, input logic [31:0] pc,
                        input logic fl, input logic dn, input logic [31:0] dt);
        rst = r; rdy = rd; pc_in = pc; flush = fl; mem_done = dn; mem_data = dt;
        @(posedge clk);
        model_update(r, rd, pc, fl, dn, dt);
        #1;
    endtask

    task automatic test_reset;
        step(1, 1, 32'h0, 0, 0, 32'h0);
        step(1, 1, 32'h0, 0, 0, 32'h0);
        vectors++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", instr_valid); end
        vectors++; if (instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h exp 0", instr); end
        vectors++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h exp 0", instr_pc); end
        vectors++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b exp 0", mem_req); end
        vectors++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h exp 0", mem_addr); end
    endtask

    task automatic test_cold_miss;
        step(0, 1, 32'h0, 0, 0, 32'h0);
        vectors++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin errors++; $display("FAIL cold_req: got req=%b addr=%h exp req=1 addr=0", mem_req, mem_addr); end
        vectors++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL cold_nv: got %b exp 0", instr_valid); end
        for (int k = 0; k < 2; k++) begin
            step(0, 1, 32'h0, 0, 0, 32'h0);
            vectors++; if (mem_req !== 1'b1 || mem_addr !== 32'h0 || instr_valid !== 1'b0) begin errors++; $display("FAIL cold_wait: got req=%b addr=%h v=%b exp 1/0/0", mem_req, mem_addr, instr_valid); end
        end
        step(0, 1, 32'h0, 0, 1, 32'h0000_0013);
        vectors++; if (mem_req !== 1'b0 || instr_valid !== 1'b0) begin errors++; $display("FAIL cold_done: got req=%b v=%b exp 0/0", mem_req, instr_valid); end
        step(0, 1, 32'h0, 0, 0, 32'h0);
        vectors++; if (instr_valid !== 1'b1 || instr !== 32'h13 || instr_pc !== 32'h0) begin errors++; $display("FAIL cold_deliver: got v=%b instr=%h pc=%h exp 1/00000013/0", instr_valid, instr, instr_pc); end
    endtask

    task automatic test_hit;
        for (int k = 0; k < 3; k++) begin
            step(0, 1, (k == 1) ? 32'h3 : 32'h0, 0, 0, 32'h0);
            vectors++; if (instr_valid !== 1'b1 || instr !== 32'h13 || instr_pc !== 32'h0 || mem_req !== 1'b0) begin errors++; $display("FAIL hit_%0d: got v=%b instr=%h pc=%h req=%b exp 1/13/0/0", k, instr_valid, instr, instr_pc, mem_req); end
        end
    endtask

    task automatic test_conflict;
        step(0, 1, 32'h400, 0, 0, 32'h0);
        vectors++; if (mem_req !== 1'b1 || mem_addr !== 32'h400 || instr_valid !== 1'b0) begin errors++; $display("FAIL conf_miss: got req=%b addr=%h v=%b exp 1/400/0", mem_req, mem_addr, instr_valid); end
        step(0, 1, 32'h400, 0, 0, 32'h0);
        step(0, 1, 32'h400, 0, 1, 32'hDEAD_BEEF);
        step(0, 1, 32'h400, 0, 0, 32'h0);
        vectors++; if (instr_valid !== 1'b1 || instr !== 32'hDEAD_BEEF || instr_pc !== 32'h400) begin errors++; $display("FAIL conf_hit: got v=%b instr=%h pc=%h exp 1/deadbeef/400", instr_valid, instr, instr_pc); end
        step(0, 1, 32'h0, 0, 0, 32'h0);
        vectors++; if (instr_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h0) begin errors++; $display("FAIL conf_evict: got v=%b req=%b addr=%h exp 0/1/0", instr_valid, mem_req, mem_addr); end
        step(0, 1, 32'h0, 0, 1, 32'h0000_0013);
        step(0, 1, 32'h0, 0, 0, 32'h0);
        vectors++; if (instr_valid !== 1'b1 || instr !== 32'h13) begin errors++; $display("FAIL conf_refill: got v=%b instr=%h exp 1/13", instr_valid, instr); end
    endtask

    task automatic test_flush_miss;
        step(0, 1, 32'h804, 0, 0, 32'h0);
        vectors++; if (mem_req !== 1'b1 || mem_addr !== 32'h804) begin errors++; $display("FAIL fl_miss: got req=%b addr=%h exp 1/804", mem_req, mem_addr); end
        step(0, 1, 32'h123, 1, 0, 32'h0);
        vectors++; if (instr_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h804) begin errors++; $display("FAIL fl_mid: got v=%b req=%b addr=%h exp 0/1/804", instr_valid, mem_req, mem_addr); end
        step(0, 1, 32'h804, 1, 1, 32'hA5A5_0001);
        vectors++; if (instr_valid !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL fl_done: got v=%b req=%b exp 0/0", instr_valid, mem_req); end
        step(0, 1, 32'h804, 0, 0, 32'h0);
        vectors++; if (instr_valid !== 1'b1 || instr !== 32'hA5A5_0001 || instr_pc !== 32'h804 || mem_req !== 1'b0) begin errors++; $display("FAIL fl_hit: got v=%b instr=%h pc=%h req=%b exp 1/a5a50001/804/0", instr_valid, instr, instr_pc, mem_req); end
    endtask

    task automatic test_rdy_stall;
        step(0, 1, 32'h1008, 0, 0, 32'h0);
        vectors++; if (mem_req !== 1'b1 || mem_addr !== 32'h1008) begin errors++; $display("FAIL st_miss: got req=%b addr=%h exp 1/1008", mem_req, mem_addr); end
        for (int k = 0; k < 5; k++) begin
            step(0, 0, $urandom(), (k == 1), (k == 2), 32'hBAD0_BAD0);
            vectors++; if (mem_req !== 1'b1 || mem_addr !== 32'h1008 || instr_valid !== 1'b0) begin errors++; $display("FAIL st_hold_%0d: got req=%b addr=%h v=%b exp 1/1008/0", k, mem_req, mem_addr, instr_valid); end
        end
        step(0, 1, $urandom(), 0, 0, 32'h0);
        vectors++; if (mem_req !== 1'b1 || mem_addr !== 32'h1008) begin errors++; $display("FAIL st_resume: got req=%b addr=%h exp 1/1008", mem_req, mem_addr); end
        step(0, 1, 32'h1008, 0, 1, 32'h1111_2222);
        vectors++; if (mem_req !== 1'b0 || instr_valid !== 1'b0) begin errors++; $display("FAIL st_done: got req=%b v=%b exp 0/0", mem_req, instr_valid); end
        step(0, 1, 32'h1008, 0, 0, 32'h0);
        vectors++; if (instr_valid !== 1'b1 || instr !== 32'h1111_2222 || instr_pc !== 32'h1008) begin errors++; $display("FAIL st_hit: got v=%b instr=%h pc=%h exp 1/11112222/1008", instr_valid, instr, instr_pc); end
    endtask

    task automatic test_reset_in_miss;
        step(0, 1, 32'h2000, 0, 0, 32'h0);
        vectors++; if (mem_req !== 1'b1 || mem_addr !== 32'h2000) begin errors++; $display("FAIL rm_miss: got req=%b addr=%h exp 1/2000", mem_req, mem_addr); end
        step(1, 1, 32'h2000, 0, 0, 32'h0);
        vectors++; if (mem_req !== 1'b0 || instr_valid !== 1'b0 || mem_addr !== 32'h0) begin errors++; $display("FAIL rm_rst: got req=%b v=%b addr=%h exp 0/0/0", mem_req, instr_valid, mem_addr); end
        step(0, 1, 32'h0, 1, 1, 32'hBADB_AD00);
        vectors++; if (mem_req !== 1'b0 || instr_valid !== 1'b0) begin errors++; $display("FAIL rm_stray: got req=%b v=%b exp 0/0", mem_req, instr_valid); end
        step(0, 1, 32'h0, 0, 0, 32'h0);
        vectors++; if (mem_req !== 1'b1 || mem_addr !== 32'h0 || instr_valid !== 1'b0) begin errors++; $display("FAIL rm_remiss: got req=%b addr=%h v=%b exp 1/0/0", mem_req, mem_addr, instr_valid); end
        step(0, 1, 32'h0, 0, 1, 32'h0000_0013);
        step(0, 1, 32'h2000, 0, 0, 32'h0);
        vectors++; if (mem_req !== 1'b1 || mem_addr !== 32'h2000) begin errors++; $display("FAIL rm_nofill: got req=%b addr=%h exp 1/2000", mem_req, mem_addr); end
        step(0, 1, 32'h2000, 0, 1, 32'hCAFE_F00D);
    endtask

    task automatic test_random;
        logic        r, rd, fl, dn;
        logic [31:0] pc;
        for (int i = 0; i < 3000; i++) begin
            r  = ($urandom_range(0, 199) == 0);
            rd = ($urandom_range(0, 99) < 85);
            pc = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
            fl = ($urandom_range(0, 9) == 0);
            dn = m_miss ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
            step(r, rd, pc, fl, dn, $urandom());
            vectors++; if (instr_valid !== e_v) begin errors++; $display("FAIL rnd_valid @%0d: got %b exp %b", i, instr_valid, e_v); end
            vectors++; if (e_v && (instr !== e_instr || instr_pc !== e_pc)) begin errors++; $display("FAIL rnd_instr @%0d: got %h@%h exp %h@%h", i, instr, instr_pc, e_instr, e_pc); end
            vectors++; if (mem_req !== e_req) begin errors++; $display("FAIL rnd_req @%0d: got %b exp %b", i, mem_req, e_req); end
            vectors++; if (e_req && mem_addr !== e_addr) begin errors++; $display("FAIL rnd_addr @%0d: got %h exp %h", i, mem_addr, e_addr); end
        end
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; pc_in = '0; flush = 1'b0; mem_done = 1'b0; mem_data = '0;
        test_reset;
        test_cold_miss;
        test_hit;
        test_conflict;
        test_flush_miss;
        test_rdy_stall;
        test_reset_in_miss;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
